enc_scheduler: RTL and testbench
================================

ENC_SCHEDULER -- requirements
Module: enc_scheduler

Interface
REQ-001 SHALL have parameter ENC_SYM, default 4: symbols per output beat.
REQ-002 SHALL have parameter RSC_MES_LEN, default 11: message symbols per codeword (K); constraint K >= ENC_SYM.
REQ-003 SHALL have parameter RSC_PAR_LEN, default 6: parity symbols per codeword (P); constraint P >= ENC_SYM.
REQ-004 SHALL have parameter ENC_MES_BUF_DEP, default 16: message buffer depth in symbols; constraint >= 2*ENC_SYM.
REQ-005 SHALL have parameter ENC_PAR_BUF_DEP, default 8: parity buffer depth; carried for offset width only.
REQ-006 clk  input  1  clock, all state on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 mes_push  input  clog2(ENC_SYM+1)  message symbols written into message buffer this cycle.
REQ-009 par_valid  input  1  parity of current codeword is available from processor.
REQ-010 out_ready  input  1  downstream accepts current beat.
REQ-011 out_valid  output  1  current beat complete and presentable.
REQ-012 sel_phase  output  SEL_PHASE  SEL_MES / SEL_MTP / SEL_PAR / SEL_PTM.
REQ-013 mes_request  output  clog2(ENC_SYM+1)  message symbols of next codeword in an SEL_PTM beat, else 0.
REQ-014 par_request  output  clog2(ENC_SYM+1)  parity symbols in an SEL_MTP beat, else 0.
REQ-015 mes_offset  output  clog2(ENC_MES_BUF_DEP+1)  message window base; always 0 (buffer head-aligned).
REQ-016 par_offset  output  clog2(ENC_PAR_BUF_DEP+1)  parity index of first parity symbol in beat.
REQ-017 mes_pop  output  clog2(ENC_SYM+1)  message symbols consumed on this cycle's handshake, else 0.
REQ-018 par_ack  output  1  one-cycle pulse: last parity symbol of codeword consumed.
REQ-019 ovf_err  output  1  sticky message-buffer overflow flag.

Function
REQ-020 SHALL hold pos (0..K+P-1, codeword symbol position of beat lane 0) and mes_level (symbols held in message buffer) as registers; all outputs decoded combinationally from pos, mes_level, par_valid, out_ready.
REQ-021 Phase decode, N=K+P: pos+S<=K -> SEL_MES; pos<K<pos+S -> SEL_MTP; pos>=K and pos+S<=N -> SEL_PAR; pos>=K and pos+S>N -> SEL_PTM.
REQ-022 SEL_MTP: par_request=S-(K-pos), par_offset=0; message need K-pos.
REQ-023 SEL_PAR: par_offset=pos-K; message need 0.
REQ-024 SEL_PTM: mes_request=pos+S-N, par_offset=pos-K; message need mes_request.
REQ-025 SEL_MES: message need S; par_offset=0.
REQ-026 out_valid SHALL be 1 iff mes_level >= message need and (phase==SEL_MES or par_valid==1).
REQ-027 Handshake: beat fires when out_valid && out_ready; on fire pos <= pos+S if pos+S<N else pos+S-N; otherwise pos holds.
REQ-028 mes_pop SHALL equal message need on fire, 0 otherwise.
REQ-029 mes_level <= mes_level + mes_push - mes_pop each cycle; push and pop in same cycle SHALL both apply.
REQ-030 If mes_level+mes_push-mes_pop > ENC_MES_BUF_DEP, ovf_err SHALL set and stay 1 until reset; mes_level saturates at ENC_MES_BUF_DEP.
REQ-031 par_ack SHALL pulse on fire of a SEL_PTM beat or of a SEL_PAR beat with pos+S==N.
REQ-032 Beat with out_valid=0 SHALL not advance even if out_ready=1; outputs other than out_valid and mes_pop remain stable while stalled.
REQ-033 A beat SHALL never span more than one codeword boundary (guaranteed by REQ-002/003).

Reset
REQ-034 On rst_n low, immediately: pos=0, mes_level=0, ovf_err=0; hence sel_phase=SEL_MES, out_valid=0, mes_pop=0, par_ack=0, requests=0, offsets=0.
REQ-035 Reset mid-codeword SHALL discard position; first beat after release starts a new codeword at pos=0.

Verification (K=11, P=6, S=4, par_valid=1, out_ready=1, ample message)
REQ-036 Continuous stream -> pos 0,4,8,12,16,3,7,11,15,2; phases MES,MES,MTP,PAR,PTM,MES,MES,PAR,PTM,MES.
REQ-037 pos=8 beat -> SEL_MTP, par_request=1, mes_pop=3; pos=16 beat -> SEL_PTM, mes_request=3, par_offset=5, mes_pop=3, par_ack=1.
REQ-038 pos=15 beat -> SEL_PTM, mes_request=2, par_offset=4, par_ack=1; pos=11 beat -> SEL_PAR, par_offset=0, mes_pop=0.
REQ-039 mes_level=2 at pos=0 -> out_valid=0, pos holds; push 2 -> out_valid=1 next cycle, fire pops 4.
REQ-040 par_valid=0 at pos=8 -> stall; out_ready toggling -> no advance; par_valid=1 -> fire; reset asserted at pos=12 -> pos=0, out_valid=0; push 20 into empty buffer -> ovf_err=1 sticky.

Source files
------------

// File: rtl/enc_scheduler.sv
// enc_scheduler: sequences codeword beats (message, parity, boundary-straddling mixes) and tracks message-buffer fill.
module enc_scheduler #(
  parameter int ENC_SYM         = 4,
  parameter int RSC_MES_LEN     = 11,
  parameter int RSC_PAR_LEN     = 6,
  parameter int ENC_MES_BUF_DEP = 16,
  parameter int ENC_PAR_BUF_DEP = 8,
  localparam int SW  = $clog2(ENC_SYM + 1),
  localparam int MOW = $clog2(ENC_MES_BUF_DEP + 1),
  localparam int POW = $clog2(ENC_PAR_BUF_DEP + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [SW-1:0]  mes_push,
  input  logic           par_valid,
  input  logic           out_ready,
  output logic           out_valid,
  output logic [1:0]     sel_phase,
  output logic [SW-1:0]  mes_request,
  output logic [SW-1:0]  par_request,
  output logic [MOW-1:0] mes_offset,
  output logic [POW-1:0] par_offset,
  output logic [SW-1:0]  mes_pop,
  output logic           par_ack,
  output logic           ovf_err
);
  localparam int N  = RSC_MES_LEN + RSC_PAR_LEN;
  localparam int PW = $clog2(N + ENC_SYM + 1);
  localparam int WW = (PW > MOW ? PW : MOW) + 1;
  localparam logic [1:0] SEL_MES = 2'd0, SEL_MTP = 2'd1, SEL_PAR = 2'd2, SEL_PTM = 2'd3;
  localparam logic [PW-1:0] S_P = PW'(ENC_SYM), K_P = PW'(RSC_MES_LEN), N_P = PW'(N);
  localparam logic [WW-1:0] DEP_W = WW'(ENC_MES_BUF_DEP);
  logic [PW-1:0]  pos_q, pos_d, pos_end, need;
  logic [MOW-1:0] lvl_q, lvl_d;
  logic [WW-1:0]  lvl_sum;
  logic           ovf_q, ovf_d, fire;
  always_comb begin
    pos_end     = pos_q + S_P;
    sel_phase   = pos_end <= K_P ? SEL_MES : pos_q < K_P ? SEL_MTP : pos_end <= N_P ? SEL_PAR : SEL_PTM;
    need        = sel_phase == SEL_MES ? S_P :
                  sel_phase == SEL_MTP ? K_P - pos_q :
                  sel_phase == SEL_PTM ? pos_end - N_P : '0;
    out_valid   = WW'(lvl_q) >= WW'(need) && (sel_phase == SEL_MES || par_valid);
    fire        = out_valid && out_ready;
    mes_request = sel_phase == SEL_PTM ? SW'(pos_end - N_P) : '0;
    par_request = sel_phase == SEL_MTP ? SW'(pos_end - K_P) : '0;
    // PAR and PTM share the msb, and both start inside the parity region
    par_offset  = sel_phase[1] ? POW'(pos_q - K_P) : '0;
    mes_offset  = '0;
    mes_pop     = fire ? SW'(need) : '0;
    par_ack     = fire && (sel_phase == SEL_PTM || (sel_phase == SEL_PAR && pos_end == N_P));
    pos_d       = !fire ? pos_q : pos_end < N_P ? pos_end : pos_end - N_P;
    lvl_sum     = WW'(lvl_q) + WW'(mes_push) - WW'(mes_pop);
    ovf_d       = ovf_q || lvl_sum > DEP_W;
    lvl_d       = lvl_sum > DEP_W ? MOW'(ENC_MES_BUF_DEP) : MOW'(lvl_sum);
  end
  assign ovf_err = ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= '0;
      lvl_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      pos_q <= pos_d;
      lvl_q <= lvl_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_enc_scheduler.sv
// tb_enc_scheduler: lane-by-lane reference model of the codeword schedule with table, directed and random stimulus.
module tb_enc_scheduler;
  localparam int S = 4, K = 11, P = 6, N = K + P, D = 16;
  localparam int MES = 0, MTP = 1, PAR = 2, PTM = 3;
  typedef struct {int valid; int phase; int mreq; int preq; int poff; int pop; int ack;} rec_t;
  typedef struct {int push; rec_t e;} vec_t;
  logic clk = 0, rst_n = 0;
  logic [2:0] mes_push = '0;
  logic par_valid = 0, out_ready = 0;
  logic out_valid, par_ack, ovf_err;
  logic [1:0] sel_phase;
  logic [2:0] mes_request, par_request, mes_pop;
  logic [4:0] mes_offset;
  logic [3:0] par_offset;
  int errs = 0, checks = 0;
  int m_pos = 0, m_lvl = 0, m_ovf = 0;
  rec_t o;
  vec_t tbl[10];

  enc_scheduler dut (
    .clk(clk), .rst_n(rst_n), .mes_push(mes_push), .par_valid(par_valid), .out_ready(out_ready),
    .out_valid(out_valid), .sel_phase(sel_phase), .mes_request(mes_request), .par_request(par_request),
    .mes_offset(mes_offset), .par_offset(par_offset), .mes_pop(mes_pop), .par_ack(par_ack), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  // Classify each lane of the beat as current message, parity, or next-codeword message.
  function automatic rec_t predict(int pos, int lvl, int pv, int rdy);
    rec_t r;
    int msg = 0, par = 0, nxt = 0, first = -1, need;
    bit last = 0;
    for (int i = 0; i < S; i++) begin
      int p = pos + i;
      if (p < K) msg++;
      else if (p < N) begin
        par++;
        if (first < 0) first = p - K;
        if (p == N - 1) last = 1;
      end else nxt++;
    end
    r.phase = (par == 0) ? MES : (msg > 0) ? MTP : (nxt > 0) ? PTM : PAR;
    need = msg + nxt;
    r.valid = (lvl >= need && (r.phase == MES || pv != 0)) ? 1 : 0;
    r.mreq = (r.phase == PTM) ? nxt : 0;
    r.preq = (r.phase == MTP) ? par : 0;
    r.poff = (r.phase == PAR || r.phase == PTM) ? first : 0;
    r.pop = (r.valid != 0 && rdy != 0) ? need : 0;
    r.ack = (r.valid != 0 && rdy != 0 && last) ? 1 : 0;
    return r;
  endfunction

  task automatic step(int push, int pv, int rdy, output rec_t ob);
    rec_t e;
    mes_push = 3'(push);
    par_valid = pv[0];
    out_ready = rdy[0];
    @(negedge clk);
    ob = '{int'(out_valid), int'(sel_phase), int'(mes_request), int'(par_request),
           int'(par_offset), int'(mes_pop), int'(par_ack)};
    e = predict(m_pos, m_lvl, pv, rdy);
    chk("out_valid", ob.valid, e.valid);
    chk("sel_phase", ob.phase, e.phase);
    chk("mes_request", ob.mreq, e.mreq);
    chk("par_request", ob.preq, e.preq);
    chk("par_offset", ob.poff, e.poff);
    chk("mes_pop", ob.pop, e.pop);
    chk("par_ack", ob.ack, e.ack);
    chk("ovf_err", ovf_err, m_ovf);
    chk("mes_offset", mes_offset, 0);
    if (e.valid != 0 && rdy != 0) m_pos = (m_pos + S) % N;
    m_lvl = m_lvl + push - e.pop;
    if (m_lvl > D) begin
      m_ovf = 1;
      m_lvl = D;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(string n);
    chk({n, "_valid"}, out_valid, 0);
    chk({n, "_phase"}, sel_phase, MES);
    chk({n, "_pop"}, mes_pop, 0);
    chk({n, "_ack"}, par_ack, 0);
    chk({n, "_reqs"}, {mes_request, par_request}, 0);
    chk({n, "_offs"}, {mes_offset, par_offset}, 0);
    chk({n, "_ovf"}, ovf_err, 0);
  endtask

  task automatic do_reset(string n);
    @(posedge clk);
    #2;
    mes_push = '0;
    rst_n = 0;
    #1;
    chk_reset_outs(n);
    m_pos = 0; m_lvl = 0; m_ovf = 0;
    #4;
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{4, '{1, MES, 0, 0, 0, 4, 0}};
    tbl[1] = '{4, '{1, MES, 0, 0, 0, 4, 0}};
    tbl[2] = '{3, '{1, MTP, 0, 1, 0, 3, 0}};
    tbl[3] = '{0, '{1, PAR, 0, 0, 1, 0, 0}};
    tbl[4] = '{3, '{1, PTM, 3, 0, 5, 3, 1}};
    tbl[5] = '{4, '{1, MES, 0, 0, 0, 4, 0}};
    tbl[6] = '{4, '{1, MES, 0, 0, 0, 4, 0}};
    tbl[7] = '{0, '{1, PAR, 0, 0, 0, 0, 0}};
    tbl[8] = '{2, '{1, PTM, 2, 0, 4, 2, 1}};
    tbl[9] = '{4, '{1, MES, 0, 0, 0, 4, 0}};
    #3;
    chk_reset_outs("por");
    #9;
    rst_n = 1;
    @(posedge clk);
    #1;
    // underfilled buffer at pos 0 holds until enough symbols arrive
    step(2, 1, 1, o);
    chk("low_lvl_valid0", o.valid, 0);
    step(2, 1, 1, o);
    chk("lvl2_valid0", o.valid, 0);
    step(0, 1, 1, o);
    chk("lvl4_valid1", o.valid, 1);
    chk("lvl4_pop4", o.pop, 4);
    // steady stream with the buffer held at 12 symbols
    do_reset("rst_a");
    for (int i = 0; i < 3; i++) step(4, 1, 0, o);
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].push, 1, 1, o);
      chk($sformatf("tbl%0d_phase", i), o.phase, tbl[i].e.phase);
      chk($sformatf("tbl%0d_valid", i), o.valid, tbl[i].e.valid);
      chk($sformatf("tbl%0d_mreq", i), o.mreq, tbl[i].e.mreq);
      chk($sformatf("tbl%0d_preq", i), o.preq, tbl[i].e.preq);
      chk($sformatf("tbl%0d_poff", i), o.poff, tbl[i].e.poff);
      chk($sformatf("tbl%0d_pop", i), o.pop, tbl[i].e.pop);
      chk($sformatf("tbl%0d_ack", i), o.ack, tbl[i].e.ack);
    end
    // parity stall at pos 8, then reset mid-codeword at pos 12
    do_reset("rst_b");
    for (int i = 0; i < 3; i++) step(4, 1, 0, o);
    step(4, 1, 1, o);
    step(4, 1, 1, o);
    step(0, 0, 1, o);
    chk("stall_valid", o.valid, 0);
    chk("stall_phase", o.phase, MTP);
    step(0, 0, 0, o);
    step(0, 0, 1, o);
    chk("stall_hold_phase", o.phase, MTP);
    chk("stall_hold_preq", o.preq, 1);
    chk("stall_pop", o.pop, 0);
    step(0, 1, 1, o);
    chk("unstall_pop", o.pop, 3);
    step(0, 1, 0, o);
    chk("pos12_phase", o.phase, PAR);
    do_reset("rst_mid");
    step(0, 1, 1, o);
    chk("post_rst_phase", o.phase, MES);
    chk("post_rst_valid", o.valid, 0);
    // overflow: 20 symbols into an empty 16-deep buffer
    for (int i = 0; i < 5; i++) step(4, 1, 0, o);
    step(0, 1, 1, o);
    chk("ovf_set", ovf_err, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 1, o);
    chk("ovf_sticky", ovf_err, 1);
    do_reset("rst_c");
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 4), ($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 1), o);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
